// File: rtl/cim_pkg.sv
// Shared CIM datapath constants. The ReLU stage and the macro wrapper import
// the same values, so lane count and bus widths stay aligned across blocks.
package cim_pkg;

  localparam int LANES      = 64;
  localparam int PSUM_WIDTH = 10;
  localparam int ACC_WIDTH  = 18;
  localparam int IN_BITS    = 4;

  // Width of a counter spanning 0..n-1, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/psum_lane.sv
// One output lane: shifts the incoming signed partial sum by its bit-plane
// weight and adds it into a saturating accumulator.
module psum_lane #(
  parameter int PSUM_WIDTH = cim_pkg::PSUM_WIDTH,
  parameter int ACC_WIDTH  = cim_pkg::ACC_WIDTH,
  parameter int BIT_W      = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         beat,
  input  logic                         restart,
  input  logic [BIT_W-1:0]             bit_idx,
  input  logic signed [PSUM_WIDTH-1:0] psum,
  output logic signed [ACC_WIDTH-1:0]  sum,
  output logic                         sat
);

  // One guard bit above the accumulator is enough: both operands fit in
  // ACC_WIDTH bits, so their sum fits in ACC_WIDTH+1.
  localparam int SW = ACC_WIDTH + 1;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [SW-1:0]        term;
  logic signed [SW-1:0]        raw;

  assign term = $signed({{(SW-PSUM_WIDTH){psum[PSUM_WIDTH-1]}}, psum}) <<< bit_idx;
  assign raw  = $signed({acc[ACC_WIDTH-1], acc}) + term;
  // Guard bit disagreeing with the sign bit means the true sum left the range.
  assign sat  = raw[SW-1] ^ raw[SW-2];
  assign sum  = sat ? (raw[SW-1] ? ACC_MIN : ACC_MAX) : raw[ACC_WIDTH-1:0];

  // Accumulate clamped sums; a finished or aborted frame starts again from 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (restart) begin
      acc <= '0;
    end else if (beat) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/psum_accumulator.sv
// Shift-add accumulator for bit-serial CIM partial sums across activation
// bit-planes and row tiles; publishes one saturated result per frame.
module psum_accumulator #(
  parameter int LANES      = cim_pkg::LANES,
  parameter int PSUM_WIDTH = cim_pkg::PSUM_WIDTH,
  parameter int ACC_WIDTH  = cim_pkg::ACC_WIDTH,
  parameter int IN_BITS    = cim_pkg::IN_BITS,
  parameter int ROW_TILES  = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        psum_valid,
  input  logic [LANES*PSUM_WIDTH-1:0] psum_in,
  input  logic                        psum_clear,
  output logic [LANES*ACC_WIDTH-1:0]  acc_out,
  output logic                        acc_valid,
  output logic                        acc_sat,
  output logic                        busy
);

  localparam int BIT_W  = cim_pkg::idx_width(IN_BITS);
  localparam int TILE_W = cim_pkg::idx_width(ROW_TILES);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(IN_BITS - 1);
  localparam logic [TILE_W-1:0] TILE_LAST = TILE_W'(ROW_TILES - 1);

  // A shifted partial sum must fit the accumulator without prior clamping.
  if (PSUM_WIDTH + IN_BITS - 1 > ACC_WIDTH) begin : g_bad_width
    $error("psum_accumulator: PSUM_WIDTH+IN_BITS-1 exceeds ACC_WIDTH");
  end
  if (ROW_TILES < 1) begin : g_bad_tiles
    $error("psum_accumulator: ROW_TILES must be at least 1");
  end

  logic [BIT_W-1:0]           bit_idx;
  logic [TILE_W-1:0]          tile_idx;
  logic                       beat;
  logic                       final_beat;
  logic                       restart;
  logic                       frame_sat;
  logic [LANES-1:0]           lane_sat;
  logic [LANES*ACC_WIDTH-1:0] lane_sum;

  // Clear outranks a beat, including a final one, so that beat is dropped.
  assign beat       = psum_valid && !psum_clear;
  assign final_beat = beat && (bit_idx == BIT_LAST) && (tile_idx == TILE_LAST);
  assign restart    = psum_clear || final_beat;
  // Counters sit at zero exactly when no part of a frame is held.
  assign busy       = (bit_idx != '0) || (tile_idx != '0);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    psum_lane #(
      .PSUM_WIDTH (PSUM_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH),
      .BIT_W      (BIT_W)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .beat    (beat),
      .restart (restart),
      .bit_idx (bit_idx),
      .psum    (psum_in[PSUM_WIDTH*(i+1)-1 -: PSUM_WIDTH]),
      .sum     (lane_sum[ACC_WIDTH*(i+1)-1 -: ACC_WIDTH]),
      .sat     (lane_sat[i])
    );
  end

  // Beat position: bit-planes inner, row tiles outer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx  <= '0;
      tile_idx <= '0;
    end else if (restart) begin
      bit_idx  <= '0;
      tile_idx <= '0;
    end else if (beat) begin
      if (bit_idx == BIT_LAST) begin
        bit_idx  <= '0;
        tile_idx <= tile_idx + TILE_W'(1);
      end else begin
        bit_idx <= bit_idx + BIT_W'(1);
      end
    end
  end

  // Sticky record of any lane clamping within the current frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_sat <= 1'b0;
    end else if (restart) begin
      frame_sat <= 1'b0;
    end else if (beat) begin
      frame_sat <= frame_sat | (|lane_sat);
    end
  end

  // Publish the final beat's clamped sums; hold them until the next frame ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_out   <= '0;
      acc_valid <= 1'b0;
      acc_sat   <= 1'b0;
    end else begin
      acc_valid <= final_beat;
      if (final_beat) begin
        acc_out <= lane_sum;
        acc_sat <= frame_sat | (|lane_sat);
      end
    end
  end

endmodule

// File: doc/psum_accumulator.md
# psum_accumulator

Sits directly upstream of the ReLU/requantise stage. It accepts bit-serial signed partial sums from the CIM macro for 64 lanes and shift-adds them across activation bit-planes and row tiles. Each finished signed accumulation is registered, saturated to ACC_WIDTH, and drives the ReLU input bus, with a one-cycle completion pulse.

## Interface

Parameters:
- LANES, 64, number of parallel output lanes (columns).
- PSUM_WIDTH, 10, signed width of one macro partial sum per lane.
- ACC_WIDTH, 18, signed accumulator/output width per lane; must equal the ReLU IN_PRECISION.
- IN_BITS, 4, unsigned activation bit-planes per tile (LSB plane first).
- ROW_TILES, 2, row tiles summed into one result; must be at least 1.
- Legal configuration: PSUM_WIDTH+IN_BITS-1 ≤ ACC_WIDTH.

Ports:
- clk, input, 1, clock; all state on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- psum_valid, input, 1, one beat present on psum_in this cycle. The block is always ready.
- psum_in, input, LANES*PSUM_WIDTH, signed partial sums; lane i at [PSUM_WIDTH*(i+1)-1 -: PSUM_WIDTH].
- psum_clear, input, 1, synchronous abort of the frame in progress.
- acc_out, output, LANES*ACC_WIDTH, signed results, same lane packing; registered.
- acc_valid, output, 1, one-cycle pulse when acc_out has just been updated.
- acc_sat, output, 1, at least one lane saturated during the frame; valid when acc_valid is 1.
- busy, output, 1, frame partially accumulated (at least one beat accepted, not yet complete).

## Operation

- **Counters.**
  - bit_idx counts 0..IN_BITS-1 (inner loop); tile_idx counts 0..ROW_TILES-1 (outer loop).
  - One frame is IN_BITS*ROW_TILES beats.
  - Beat order is fixed: tile 0 bits 0..IN_BITS-1, then tile 1, and so on.
- **Per accepted beat, each lane:**
  - term = sign-extend(psum) << bit_idx.
  - acc = sat(acc + term).
  - The sum is computed at ACC_WIDTH+1 bits and clamped to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - Saturation is applied on every add (sticky clamping, not just at the end).
  - Any lane clamping sets the frame's sat flag.
- **Final beat** (bit_idx=IN_BITS-1 and tile_idx=ROW_TILES-1):
  - The saturated final sum is written to acc_out, sat flag to acc_sat, and acc_valid is pulsed.
  - Accumulators, counters and sat flag return to 0 on the same edge, so the next frame's first beat may arrive the very next cycle.
- **Idle:** acc_out and acc_sat hold their last values between frames.
- **psum_clear:**
  - Accumulators, counters, sat flag and busy go to 0. No acc_valid pulse; acc_out is unchanged.
  - Clear together with psum_valid: clear wins and the beat is dropped.
  - Clear in the same cycle as a final beat: the beat is dropped and no result is produced.
- **No valid:** when psum_valid=0, all state holds.

## Timing

- Reset values: acc_out=0, acc_valid=0, acc_sat=0, busy=0; internal accumulators and counters are also 0.
- Reset asserted mid-frame discards the frame immediately, asynchronously.
- Latency: acc_out/acc_valid update on the edge that accepts the final beat. They are visible the cycle after that beat is presented.
- The ReLU registers acc_out one further cycle, giving 2 cycles from the final beat to relu_out.
- Throughput: one beat per cycle; back-to-back frames give acc_valid once every IN_BITS*ROW_TILES cycles.
- busy goes to 1 on the edge accepting a frame's first beat. It goes to 0 on the edge accepting the final beat or a clear.
- With IN_BITS*ROW_TILES=1, every beat is final and busy stays 0.

## Structure

- Shared package cim_pkg holds LANES, PSUM_WIDTH, ACC_WIDTH and IN_BITS as constants, shared with the ReLU and macro wrapper so widths cannot drift.
- Sub-module psum_lane: one lane's shift, sign-extend, saturating add, accumulator register and sat output. It is instantiated LANES times under a generate loop.
- The top level owns bit_idx/tile_idx, final-beat decode, clear priority, the acc_out/acc_valid/acc_sat registers, and ORs the lane sat flags.

## Test plan

- **Basic accumulation.** Reset, then 8 beats with lane 0 psum=+1 and lane 63 psum=-1 on every beat (defaults). Required: acc_valid pulses once, on the cycle after beat 8. Lane 0 = 30, lane 63 = -30, acc_sat=0, busy high during beats 2–8.
- **Weight per bit-plane.** Tile 0 psums 1,0,0,0 and tile 1 psums 0,0,0,-1. Required: result = 1 - 8 = -7 (0x3FFF9 in 18 bits).
- **Back-to-back frames.** Two 8-beat frames with no gap: frame A all psum=+5, frame B all psum=-512. Required: results 150 then -15360, with acc_valid pulses exactly 8 cycles apart and no carry-over between frames.
- **Saturation.** ROW_TILES=32, all beats psum=+511 on lane 5. Required: lane 5 = 131071, acc_sat=1, other lanes (psum 0) = 0.
- **Clear.** Clear asserted together with beat 5 of a frame. Required: no acc_valid, busy=0, acc_out unchanged from the previous frame. A fresh 8-beat frame of psum=+1 then yields 30.
- **Async reset mid-frame.** Drop rst_n between beats 3 and 4 without a clock edge. Required: outputs 0 immediately. After release, a full frame produces the correct result.
